// File: rtl/vga_pkg.sv
// Shared VGA timing presets, colour-bar table and window helpers.
// The colour-bar helpers are only used when TEST_PATTERN_EN is defined.
package vga_pkg;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam bit VGA640_HS_POL   = 1'b0;
   localparam bit VGA640_VS_POL   = 1'b0;

   // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;
   localparam bit SVGA800_HS_POL   = 1'b1;
   localparam bit SVGA800_VS_POL   = 1'b1;

   // RGB332 colour bars, left to right
   localparam logic [7:0] BAR_COLOURS [8] = '{
      8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
   };

   function automatic logic in_window(input int pos, input int start, input int len);
      return (pos >= start) && (pos < start + len);
   endfunction

   function automatic logic [2:0] bar_index(input int pos, input int active);
      return 3'((pos * 8) / active);
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register of DEPTH stages with a configurable reset value.
// DEPTH=0 is a straight wire.
module vga_sync_delay #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_bypass
      assign dout = din;
   end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
         end else if (en) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
         end
      end

      assign dout = stages[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: early pixel requests, sync/de delayed by SRC_LAT.
// Optional macro TEST_PATTERN_EN adds a pattern_en input selecting colour bars.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = VGA640_H_ACTIVE,
   parameter int H_FP      = VGA640_H_FP,
   parameter int H_SYNC    = VGA640_H_SYNC,
   parameter int H_BP      = VGA640_H_BP,
   parameter int V_ACTIVE  = VGA640_V_ACTIVE,
   parameter int V_FP      = VGA640_V_FP,
   parameter int V_SYNC    = VGA640_V_SYNC,
   parameter int V_BP      = VGA640_V_BP,
   parameter bit HSYNC_POL = VGA640_HS_POL,
   parameter bit VSYNC_POL = VGA640_VS_POL,
   parameter int PIX_W     = 8,
   parameter int SRC_LAT   = 2,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
`ifdef TEST_PATTERN_EN
   input  logic             pattern_en,
`endif
   input  logic [PIX_W-1:0] pix_in,
   output logic [XW-1:0]    req_x,
   output logic [YW-1:0]    req_y,
   output logic             req_valid,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [PIX_W-1:0] rgb,
   output logic             frame_start,
   output logic             line_start
);

   if (SRC_LAT < 0 || SRC_LAT > 15) begin : g_bad_src_lat
      $error("vga_timing_gen: SRC_LAT must be in 0..15");
   end

   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] X_ACTIVE = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_ACTIVE = YW'(V_ACTIVE);

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          x_active, y_active;
   logic          hs_raw, vs_raw, de_raw, fs_raw, ls_raw;
   logic          hs_dly, vs_dly, de_dly, fs_dly, ls_dly;
   logic [PIX_W-1:0] pix_sel;

   // Raster counters; x and y both wrap on the last pixel of the frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   assign x_active  = (x < X_ACTIVE);
   assign y_active  = (y < Y_ACTIVE);
   assign req_x     = x;
   assign req_y     = y;
   assign req_valid = en & x_active & y_active;

   assign hs_raw = in_window(32'(x), H_ACTIVE + H_FP, H_SYNC) ? HSYNC_POL : ~HSYNC_POL;
   assign vs_raw = in_window(32'(y), V_ACTIVE + V_FP, V_SYNC) ? VSYNC_POL : ~VSYNC_POL;
   assign de_raw = x_active & y_active;
   assign fs_raw = (x == '0) && (y == '0);
   assign ls_raw = (x == '0) && y_active;

   // Delayed timing bundle; with the pattern enabled the x position rides along
`ifdef TEST_PATTERN_EN
   localparam int DLY_W = 5 + XW;
   localparam logic [DLY_W-1:0] DLY_RST = {~HSYNC_POL, ~VSYNC_POL, 3'b000, {XW{1'b0}}};
   logic [XW-1:0] x_dly;
   logic [DLY_W-1:0] dly_in, dly_out;
   assign dly_in = {hs_raw, vs_raw, de_raw, fs_raw, ls_raw, x};
   assign {hs_dly, vs_dly, de_dly, fs_dly, ls_dly, x_dly} = dly_out;
`else
   localparam int DLY_W = 5;
   localparam logic [DLY_W-1:0] DLY_RST = {~HSYNC_POL, ~VSYNC_POL, 3'b000};
   logic [DLY_W-1:0] dly_in, dly_out;
   assign dly_in = {hs_raw, vs_raw, de_raw, fs_raw, ls_raw};
   assign {hs_dly, vs_dly, de_dly, fs_dly, ls_dly} = dly_out;
`endif

   vga_sync_delay #(
      .WIDTH     (DLY_W),
      .DEPTH     (SRC_LAT),
      .RESET_VAL (DLY_RST)
   ) u_sync_delay (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .din   (dly_in),
      .dout  (dly_out)
   );

`ifdef TEST_PATTERN_EN
   if (PIX_W != 8) begin : g_bad_pix_w
      $error("vga_timing_gen: TEST_PATTERN_EN requires PIX_W == 8");
   end
   assign pix_sel = pattern_en ? PIX_W'(BAR_COLOURS[bar_index(32'(x_dly), H_ACTIVE)]) : pix_in;
`else
   assign pix_sel = pix_in;
`endif

   // Output register: sync, de, pulses and pixel leave on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else if (en) begin
         hsync       <= hs_dly;
         vsync       <= vs_dly;
         de          <= de_dly;
         rgb         <= de_dly ? pix_sel : '0;
         frame_start <= fs_dly;
         line_start  <= ls_dly;
      end
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 controller.
- Runs from one pixel-rate clock qualified by a clock enable. Generates pixel-coordinate requests ahead of time for an upstream frame buffer or pattern source.
- Delays sync and blanking by a configurable source latency, so hsync, vsync, de and rgb leave the block mutually aligned.
- Sits between the pixel source (frame buffer or image pipeline) and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- PIX_W, 8, pixel data width (RGB332 at 8)
- SRC_LAT, 2, cycles from req_valid to pix_in valid; range 0..15
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  pixel enable; all counters and pipeline stages advance only when en=1
- pix_in  in  PIX_W  pixel data, valid SRC_LAT enabled cycles after the matching request
- req_x  out  XW  horizontal counter (request position)
- req_y  out  YW  vertical counter (request position)
- req_valid  out  1  en and request position inside active region
- hsync  out  1  horizontal sync, polarity HSYNC_POL, registered
- vsync  out  1  vertical sync, polarity VSYNC_POL, registered
- de  out  1  data enable (output pixel active), registered
- rgb  out  PIX_W  pixel to DAC; 0 when de=0, registered
- frame_start  out  1  one-enabled-cycle pulse with output pixel (0,0)
- line_start  out  1  one-enabled-cycle pulse with output pixel x=0 of every active line

Behaviour:
- Counter ordering per line: x in 0..H_ACTIVE-1 active, then FP, then SYNC, then BP.
  - Sync when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; same scheme vertically.
- Counters on en=1:
  - x increments; at H_TOTAL-1, x wraps to 0 and y increments.
  - y wraps to 0 at V_TOTAL-1 when x wraps. Both wrap on the same edge at (H_TOTAL-1, V_TOTAL-1).
- en=0: counters, pipeline and all registered outputs hold; req_valid=0.
- req_x/req_y are combinational copies of the counters; req_valid = en & (x<H_ACTIVE) & (y<V_ACTIVE).
- Alignment pipeline:
  - Raw hsync, vsync, de, frame_start and line_start pass through a shift register of SRC_LAT enabled stages plus one output register.
  - rgb register loads pix_in when the delayed de=1, else 0.
  - Latency: request at enabled cycle t appears on hsync/vsync/de/rgb at enabled cycle t+SRC_LAT+1.
- SRC_LAT=0: pix_in is sampled in the request cycle; still one output register.
- Reset (async, any time, including mid-frame):
  - x=0, y=0.
  - Pipeline cleared to inactive: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, rgb=0, frame_start=0, line_start=0.
  - On the first enabled cycle after release, the request position is (0,0).
- Pipeline flush after reset: the first SRC_LAT+1 output pixels are blanked (de=0, sync inactive). Downstream must tolerate this partial first frame.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined:
  - Adds input pattern_en (1 bit). When 1, pix_in is ignored.
  - rgb = colour-bar value for delayed output x: bar = x*8/H_ACTIVE.
  - Bar values for PIX_W=8: FF, FC, 1F, 1C, E3, E0, 03, 00.
  - PIX_W != 8 gives an elaboration error.
  - The delayed x is carried through the pipeline.
- Undefined: no pattern_en port, no bar logic, no extra pipeline bits.

Decomposition:
- Package vga_pkg:
  - Timing presets as localparams: 640x480@60, 800x600@60.
  - Colour-bar constant array.
  - Helper function in_window(pos, start, len).
- Sub-module vga_sync_delay: parametric enabled shift register (width, depth=SRC_LAT, reset value), used for the sync/de/pulse pipeline.

Test Plan:
- Small timing H=8/2/3/2 (total 15), V=4/1/2/1 (total 8), SRC_LAT=2, en=1 → hsync low for x=10..12; vsync low for y=5..6; frame period 120 cycles; de high 32 cycles per frame.
- Latency: pix_in = {req_y[3:0], req_x[3:0]} delayed 2 cycles by the bench → rgb at output pixel (3,2) equals 8'h23, 3 cycles after the request; rgb=0 whenever de=0.
- en toggling 1-0-1 each cycle → all outputs hold during en=0; frame period becomes 240 clocks; req_valid never high while en=0.
- Async reset asserted mid-line at (5,2) for 3 cycles → outputs go inactive immediately; after release the first request is (0,0); the first 3 output pixels are blanked; frame_start occurs 3 enabled cycles after (0,0).
- Default 640x480 parameters → 800 clocks per line, 420000 per frame; frame_start period 420000; line_start 480 times per frame.
- TEST_PATTERN_EN defined, pattern_en=1, defaults → rgb=FF for output x 0..79, FC for 80..159, …, 00 for 560..639.
